// File: rtl/iccm_loader_pkg.sv
// Shared types for the ICCM image loader.
package iccm_loader_pkg;

    typedef enum logic [2:0] {
        LDR_HDR,
        LDR_DATA,
        LDR_CHK,
        LDR_DONE,
        LDR_ERR
    } iccm_ldr_state_e;

    localparam int LDR_CKSUM_W = 8;
    localparam int LDR_WORD_W  = 32;

endpackage

// File: rtl/iccm_loader_byte_word_packer.sv
// Packs little-endian bytes into 32-bit words; flags the beat that completes a word.
module byte_word_packer
    import iccm_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic [LDR_WORD_W-1:0] word,
    output logic                  word_valid
);

    logic [1:0]            cnt;
    logic [LDR_WORD_W-1:0] sr;

    // word is the completed value on the 4th accepted byte, so the caller
    // can register it in the same cycle the last byte arrives.
    assign word       = {in_data, sr[LDR_WORD_W-1:8]};
    assign word_valid = in_valid && (cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= 2'd0;
            sr  <= '0;
        end else if (in_valid) begin
            cnt <= cnt + 2'd1;
            sr  <= word;
        end
    end

endmodule

// File: rtl/iccm_loader.sv
// Streams a length-prefixed, XOR-checked image into ICCM and holds the core
// in reset until the image is complete and verified.
module iccm_loader
    import iccm_loader_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] iccm_waddr,
    output logic [WIDTH-1:0]      iccm_wdata,
    output logic                  iccm_wen,
    output logic                  core_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    iccm_ldr_state_e state, state_nxt;

    logic                   beat;
    logic                   rearm;
    logic                   pk_valid;
    logic [LDR_WORD_W-1:0]  pk_word;
    logic                   pk_last;
    logic [ADDR_WIDTH:0]    count_q;
    logic [ADDR_WIDTH:0]    wl_inc;
    logic [LDR_CKSUM_W-1:0] cksum;
    logic                   hdr_big;
    logic                   hdr_zero;

    assign s_ready  = (state == LDR_HDR) || (state == LDR_DATA) ||
                      (state == LDR_CHK);
    assign beat     = s_valid && s_ready;
    assign rearm    = start && ((state == LDR_DONE) || (state == LDR_ERR));
    assign pk_valid = beat && ((state == LDR_HDR) || (state == LDR_DATA));
    assign wl_inc   = words_loaded + 1'b1;
    assign hdr_big  = pk_word > LDR_WORD_W'(DEPTH);
    assign hdr_zero = pk_word == '0;

    byte_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (rearm),
        .in_valid   (pk_valid),
        .in_data    (s_data),
        .word       (pk_word),
        .word_valid (pk_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= LDR_HDR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            LDR_HDR: begin
                if (pk_last) begin
                    if (hdr_big)       state_nxt = LDR_ERR;
                    else if (hdr_zero) state_nxt = LDR_CHK;
                    else               state_nxt = LDR_DATA;
                end
            end
            LDR_DATA: begin
                if (pk_last && (wl_inc == count_q)) state_nxt = LDR_CHK;
            end
            LDR_CHK: begin
                if (beat) state_nxt = (s_data == cksum) ? LDR_DONE : LDR_ERR;
            end
            LDR_DONE, LDR_ERR: begin
                if (start) state_nxt = LDR_HDR;
            end
            default: state_nxt = LDR_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iccm_wen     <= 1'b0;
            iccm_waddr   <= '0;
            iccm_wdata   <= '0;
            core_hold    <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
            count_q      <= '0;
            cksum        <= '0;
        end else begin
            iccm_wen <= 1'b0;
            if (rearm) begin
                core_hold    <= 1'b1;
                load_done    <= 1'b0;
                load_error   <= 1'b0;
                words_loaded <= '0;
                count_q      <= '0;
                cksum        <= '0;
            end else begin
                // N <= DEPTH is guaranteed on the DATA path, so it fits here.
                if (state == LDR_HDR && pk_last)
                    count_q <= pk_word[ADDR_WIDTH:0];
                if (state == LDR_DATA && beat)
                    cksum <= cksum ^ s_data;
                if (state == LDR_DATA && pk_last) begin
                    iccm_wen     <= 1'b1;
                    iccm_waddr   <= words_loaded[ADDR_WIDTH-1:0];
                    iccm_wdata   <= WIDTH'(pk_word);
                    words_loaded <= wl_inc;
                end
                if (state != LDR_DONE && state_nxt == LDR_DONE) begin
                    load_done <= 1'b1;
                    core_hold <= 1'b0;
                end
                if (state != LDR_ERR && state_nxt == LDR_ERR)
                    load_error <= 1'b1;
            end
        end
    end

endmodule
